// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for the register bank write port.
// One valid/ready transfer per cycle; the winner is registered onto wr_*.
module reg_write_arbiter #(
    parameter int N       = 32,
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 5,
    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_stall,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*N-1:0]    req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [N-1:0]            wr_data,
    output logic [ID_W-1:0]         grant_id
);

    logic [ID_W-1:0]   rr_ptr_q,   rr_ptr_d;
    logic              wr_en_q,    wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q,  wr_addr_d;
    logic [N-1:0]      wr_data_q,  wr_data_d;
    logic [ID_W-1:0]   grant_id_q, grant_id_d;

    logic              found;
    logic              xfer;
    logic [ID_W-1:0]   win_idx;
    logic [ID_W-1:0]   cand;
    logic [ADDR_W-1:0] sel_addr;
    logic [N-1:0]      sel_data;

    // (base + k) mod NUM_REQ, with k < NUM_REQ so one subtraction suffices
    function automatic logic [ID_W-1:0] wrap_idx(
        input logic [ID_W-1:0] base,
        input int              k
    );
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return s[ID_W-1:0];
    endfunction

    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = wrap_idx(rr_ptr_q, k);
            if (!found && req_valid[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign xfer = found && !reset && !wr_stall;

    always_comb begin
        req_ready = '0;
        if (xfer) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    assign sel_addr = req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
    assign sel_data = req_data[int'(win_idx)*N +: N];

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        grant_id_d = grant_id_q;
        if (xfer) begin
            rr_ptr_d   = wrap_idx(win_idx, 1);
            // x0 is hardwired: accept the write but never enable it
            wr_en_d    = (sel_addr != '0);
            wr_addr_d  = sel_addr;
            wr_data_d  = sel_data;
            grant_id_d = win_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q   <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            grant_id_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            grant_id_q <= grant_id_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign grant_id = grant_id_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed self-checking bench for reg_write_arbiter.
// Inputs change 1ns after the rising edge; outputs are checked mid-cycle.
module tb_reg_write_arbiter;

    localparam int N       = 32;
    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 5;
    localparam int ID_W    = 2;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       wr_stall;
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ*ADDR_W-1:0]  req_addr;
    logic [NUM_REQ*N-1:0]       req_data;
    logic [NUM_REQ-1:0]         req_ready;
    logic                       wr_en;
    logic [ADDR_W-1:0]          wr_addr;
    logic [N-1:0]               wr_data;
    logic [ID_W-1:0]            grant_id;

    int pass_cnt = 0;
    int total_cnt = 0;

    reg_write_arbiter #(.N(N), .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_stall  (wr_stall),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    task automatic set_req(input int i, input logic [ADDR_W-1:0] a,
                           input logic [N-1:0] d);
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_data[i*N +: N] = d;
    endtask

    // advance one edge; inputs may be changed right after this returns
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_rotation_fields();
        set_req(0, 5'd1, 32'h1111_0001);
        set_req(1, 5'd2, 32'h2222_0002);
        set_req(2, 5'd3, 32'h3333_0003);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 3'b111;
        load_rotation_fields();
        for (int c = 0; c < 2; c++) begin
            #1;
            total_cnt++;
            if (req_ready !== 3'b000)
                $display("FAIL reset_ready[%0d] got %b want 000", c, req_ready);
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if (wr_en !== 1'b0 || wr_addr !== 5'd0 || wr_data !== 32'd0 ||
            grant_id !== 2'd0)
            $display("FAIL reset_state got en=%b a=%0d d=%h g=%0d want 0 0 0 0",
                     wr_en, wr_addr, wr_data, grant_id);
        else pass_cnt++;
        reset = 1'b0;
        req_valid = 3'b000;
    endtask

    task automatic test_single();
        req_valid = 3'b010;
        set_req(1, 5'd5, 32'hDEADBEEF);
        #1;
        total_cnt++;
        if (req_ready !== 3'b010)
            $display("FAIL single_ready got %b want 010", req_ready);
        else pass_cnt++;
        tick();
        req_valid = 3'b000;
        total_cnt++;
        if (wr_en !== 1'b1 || wr_addr !== 5'd5 || wr_data !== 32'hDEADBEEF ||
            grant_id !== 2'd1)
            $display("FAIL single_write got en=%b a=%0d d=%h g=%0d want 1 5 deadbeef 1",
                     wr_en, wr_addr, wr_data, grant_id);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (wr_en !== 1'b0)
            $display("FAIL single_drop got en=%b want 0", wr_en);
        else pass_cnt++;
    endtask

    task automatic test_rotation();
        logic [1:0] exp_g;
        logic [2:0] exp_r;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        load_rotation_fields();
        req_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            exp_g = 2'(c % 3);
            exp_r = 3'b001 << exp_g;
            #1;
            total_cnt++;
            if (req_ready !== exp_r)
                $display("FAIL rot_ready[%0d] got %b want %b", c, req_ready, exp_r);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (wr_en !== 1'b1 || grant_id !== exp_g ||
                wr_addr !== 5'(exp_g + 1))
                $display("FAIL rot_write[%0d] got en=%b g=%0d a=%0d want 1 %0d %0d",
                         c, wr_en, grant_id, wr_addr, exp_g, exp_g + 1);
            else pass_cnt++;
        end
        req_valid = 3'b000;
    endtask

    task automatic test_x0();
        set_req(0, 5'd0, 32'hFFFFFFFF);
        req_valid = 3'b001;
        #1;
        total_cnt++;
        if (req_ready !== 3'b001)
            $display("FAIL x0_ready got %b want 001", req_ready);
        else pass_cnt++;
        tick();
        req_valid = 3'b000;
        total_cnt++;
        if (wr_en !== 1'b0 || wr_addr !== 5'd0 || grant_id !== 2'd0 ||
            wr_data !== 32'hFFFFFFFF)
            $display("FAIL x0_write got en=%b a=%0d g=%0d d=%h want 0 0 0 ffffffff",
                     wr_en, wr_addr, grant_id, wr_data);
        else pass_cnt++;
    endtask

    task automatic test_stall();
        // pointer is at 1; a lone requester 0 still wins
        set_req(0, 5'd7, 32'h0000_0777);
        req_valid = 3'b001;
        #1;
        total_cnt++;
        if (req_ready !== 3'b001)
            $display("FAIL stall_pre_ready got %b want 001", req_ready);
        else pass_cnt++;
        tick();
        req_valid = 3'b111;
        wr_stall = 1'b1;
        total_cnt++;
        if (wr_en !== 1'b1 || grant_id !== 2'd0 || wr_addr !== 5'd7)
            $display("FAIL stall_pre_write got en=%b g=%0d a=%0d want 1 0 7",
                     wr_en, grant_id, wr_addr);
        else pass_cnt++;
        for (int c = 0; c < 3; c++) begin
            #1;
            total_cnt++;
            if (req_ready !== 3'b000)
                $display("FAIL stall_ready[%0d] got %b want 000", c, req_ready);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (wr_en !== 1'b0 || grant_id !== 2'd0 || wr_addr !== 5'd7)
                $display("FAIL stall_hold[%0d] got en=%b g=%0d a=%0d want 0 0 7",
                         c, wr_en, grant_id, wr_addr);
            else pass_cnt++;
        end
        wr_stall = 1'b0;
        #1;
        total_cnt++;
        if (req_ready !== 3'b010)
            $display("FAIL stall_release_ready got %b want 010", req_ready);
        else pass_cnt++;
        tick();
        req_valid = 3'b000;
        total_cnt++;
        if (wr_en !== 1'b1 || grant_id !== 2'd1 || wr_addr !== 5'd2)
            $display("FAIL stall_release_write got en=%b g=%0d a=%0d want 1 1 2",
                     wr_en, grant_id, wr_addr);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        load_rotation_fields();
        req_valid = 3'b111;
        tick();
        tick();
        total_cnt++;
        if (wr_en !== 1'b1 || grant_id !== 2'd1)
            $display("FAIL mid_pre got en=%b g=%0d want 1 1", wr_en, grant_id);
        else pass_cnt++;
        reset = 1'b1;
        #1;
        total_cnt++;
        if (req_ready !== 3'b000)
            $display("FAIL mid_reset_ready got %b want 000", req_ready);
        else pass_cnt++;
        tick();
        reset = 1'b0;
        total_cnt++;
        if (wr_en !== 1'b0 || grant_id !== 2'd0 || wr_addr !== 5'd0)
            $display("FAIL mid_reset_state got en=%b g=%0d a=%0d want 0 0 0",
                     wr_en, grant_id, wr_addr);
        else pass_cnt++;
        #1;
        total_cnt++;
        if (req_ready !== 3'b001)
            $display("FAIL mid_after_ready got %b want 001", req_ready);
        else pass_cnt++;
        tick();
        req_valid = 3'b000;
        total_cnt++;
        if (wr_en !== 1'b1 || grant_id !== 2'd0 || wr_addr !== 5'd1 ||
            wr_data !== 32'h1111_0001)
            $display("FAIL mid_after_write got en=%b g=%0d a=%0d d=%h want 1 0 1 11110001",
                     wr_en, grant_id, wr_addr, wr_data);
        else pass_cnt++;
    endtask

    initial begin
        reset = 1'b1;
        wr_stall = 1'b0;
        req_valid = '0;
        req_addr = '0;
        req_data = '0;
        test_reset();
        test_single();
        test_rotation();
        test_x0();
        test_stall();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
